pos_decoder_hold: RTL and testbench

// - Inverse of the team's priority-position encoder: takes a binary position code and drives the

---
 rtl/pos_decoder_hold.sv | 91 +++++++++
 tb/tb_pos_decoder_hold.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pos_decoder_hold.sv
// Binary position code to one-hot decoder; each one-hot is held for HOLD_CYCLES cycles.
// Optional sticky accumulation mask (acc_clr/acc_mask) when POS_DEC_ACCUM_EN is defined.
module pos_decoder_hold #(
  parameter  int POS_W       = 2,
  parameter  int HOLD_CYCLES = 3,
  localparam int OUT_W       = 1 << POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  output logic             busy
`ifdef POS_DEC_ACCUM_EN
  ,
  input  logic             acc_clr,
  output logic [OUT_W-1:0] acc_mask
`endif
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [OUT_W-1:0]   decoded;

  assign decoded = {{(OUT_W-1){1'b0}}, 1'b1} << in_pos;

  // Ready only in IDLE or on the last hold cycle, so back-to-back codes leave no bubble.
  assign in_ready = rst_n && ((state == IDLE) || (cnt == '0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_onehot <= decoded;
            out_valid  <= 1'b1;
            cnt        <= CNT_LOAD;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (accept) begin
            out_onehot <= decoded;
            cnt        <= CNT_LOAD;
          end else begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef POS_DEC_ACCUM_EN
  // Clear takes effect before the OR, so a same-cycle accept survives the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_mask <= '0;
    end else if (acc_clr || accept) begin
      acc_mask <= (acc_clr ? '0 : acc_mask) | (accept ? decoded : '0);
    end
  end
`endif

endmodule

// File: tb/tb_pos_decoder_hold.sv
// Self-checking bench for pos_decoder_hold: a per-cycle scoreboard queue of expected
// one-hot values is filled on each modelled accept and drained as the DUT holds its output.
module tb_pos_decoder_hold;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_pos;
  logic       out_valid;
  logic [3:0] out_onehot;
  logic       busy;
`ifdef POS_DEC_ACCUM_EN
  logic       acc_clr;
  logic [3:0] acc_mask;
`endif

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  logic       exp_valid;
  logic [3:0] exp_oh;
  logic [3:0] exp_acc;

  pos_decoder_hold #(.POS_W(2), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .busy       (busy)
`ifdef POS_DEC_ACCUM_EN
    ,
    .acc_clr    (acc_clr),
    .acc_mask   (acc_mask)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and update the reference model; acc reports a modelled accept.
  task automatic tick(output bit acc);
    bit         rst_seen = rst_n;
    logic [3:0] oh       = 4'b0001 << in_pos;
    bit         clr      = 1'b0;
`ifdef POS_DEC_ACCUM_EN
    clr = acc_clr;
`endif
    acc = rst_seen && in_valid && (exp_q.size() == 0);
    @(posedge clk);
    #1;
    if (!rst_seen) begin
      exp_q.delete();
      exp_acc = 4'b0000;
    end else begin
      if (clr) exp_acc = 4'b0000;
      if (acc) begin
        exp_acc = exp_acc | oh;
        for (int i = 0; i < HOLD; i++) exp_q.push_back(oh);
      end
    end
    if (exp_q.size() > 0) begin
      exp_valid = 1'b1;
      exp_oh    = exp_q.pop_front();
    end else begin
      exp_valid = 1'b0;
      exp_oh    = 4'b0000;
    end
  endtask

  task automatic test_reset();
    bit a;
    rst_n = 1'b0; in_valid = 1'b1; in_pos = 2'd2;
    tick(a);
    tick(a);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot got %b want 0000", out_onehot); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    bit a;
    in_valid = 1'b1; in_pos = 2'd2;
    tick(a);
    in_valid = 1'b0;
    checks++; if (out_onehot !== 4'b0100) begin errors++; $display("FAIL single_first got %b want 0100", out_onehot); end
    for (int i = 0; i < HOLD + 2; i++) begin
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL single_valid[%0d] got %b want %b", i, out_valid, exp_valid); end
      checks++; if (out_onehot !== exp_oh) begin errors++; $display("FAIL single_onehot[%0d] got %b want %b", i, out_onehot, exp_oh); end
      checks++; if (busy !== exp_valid) begin errors++; $display("FAIL single_busy[%0d] got %b want %b", i, busy, exp_valid); end
      tick(a);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    in_valid = 1'b1; in_pos = 2'd1;
    tick(a);
    in_pos = 2'd3;
    for (int i = 0; i < 2 * HOLD + 1; i++) begin
      checks++; if (in_ready !== (rst_n && exp_q.size() == 0)) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, in_ready, exp_q.size() == 0); end
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i, out_valid, exp_valid); end
      checks++; if (out_onehot !== exp_oh) begin errors++; $display("FAIL b2b_onehot[%0d] got %b want %b", i, out_onehot, exp_oh); end
      tick(a);
      if (a) in_valid = 1'b0;
    end
  endtask

  task automatic test_sweep();
    bit a;
    for (int p = 0; p < 4; p++) begin
      in_valid = 1'b1; in_pos = 2'(p);
      tick(a);
      in_valid = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
        checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL sweep_valid[%0d.%0d] got %b want %b", p, i, out_valid, exp_valid); end
        checks++; if (out_onehot !== exp_oh) begin errors++; $display("FAIL sweep_onehot[%0d.%0d] got %b want %b", p, i, out_onehot, exp_oh); end
        tick(a);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_end[%0d] got %b want 0", p, out_valid); end
    end
  endtask

  task automatic test_reset_mid_hold();
    bit a;
    in_valid = 1'b1; in_pos = 2'd3;
    tick(a);
    in_valid = 1'b0;
    tick(a);
    rst_n = 1'b0;
    tick(a);
    checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL midrst_valid got %b want %b", out_valid, exp_valid); end
    checks++; if (out_onehot !== exp_oh) begin errors++; $display("FAIL midrst_onehot got %b want %b", out_onehot, exp_oh); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    tick(a);
    checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL midrst_idle got %b want %b", out_valid, exp_valid); end
  endtask

`ifdef POS_DEC_ACCUM_EN
  task automatic test_accum();
    bit a;
    acc_clr = 1'b1;
    tick(a);
    acc_clr = 1'b0;
    checks++; if (acc_mask !== exp_acc) begin errors++; $display("FAIL acc_clear got %b want %b", acc_mask, exp_acc); end
    in_valid = 1'b1; in_pos = 2'd0;
    tick(a);
    in_pos = 2'd3;
    for (int i = 0; i < 2 * HOLD && in_valid; i++) begin
      tick(a);
      if (a) in_valid = 1'b0;
    end
    checks++; if (acc_mask !== 4'b1001) begin errors++; $display("FAIL acc_0_3 got %b want 1001", acc_mask); end
    for (int i = 0; i < 2 * HOLD && exp_q.size() != 0; i++) tick(a);
    acc_clr = 1'b1; in_valid = 1'b1; in_pos = 2'd1;
    tick(a);
    acc_clr = 1'b0; in_valid = 1'b0;
    checks++; if (acc_mask !== 4'b0010) begin errors++; $display("FAIL acc_clr_set got %b want 0010", acc_mask); end
    checks++; if (acc_mask !== exp_acc) begin errors++; $display("FAIL acc_model got %b want %b", acc_mask, exp_acc); end
    for (int i = 0; i < HOLD + 1; i++) tick(a);
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pos = 2'd0;
    exp_valid = 1'b0; exp_oh = 4'b0000; exp_acc = 4'b0000;
`ifdef POS_DEC_ACCUM_EN
    acc_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_reset_mid_hold();
`ifdef POS_DEC_ACCUM_EN
    test_accum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
